// File: rtl/smr_ctrl_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | smr_ctrl_pkg : shared types and encodings for the SMR controller      |
// | Revision     : 1.0                                                   |
// +----------------------------------------------------------------------+
package smr_ctrl_pkg;

   typedef enum logic [3:0] {
      S_RST   = 4'd0,
      S_IF1   = 4'd1,
      S_IF2   = 4'd2,
      S_UPC   = 4'd3,
      S_GETA  = 4'd4,
      S_GETB  = 4'd5,
      S_ALU   = 4'd6,
      S_WR    = 4'd7,
      S_WRIMM = 4'd8,
      S_HALT  = 4'd9
   } state_t;

   localparam logic [2:0] OP_MOV  = 3'b110;
   localparam logic [2:0] OP_ALU  = 3'b101;
   localparam logic [2:0] OP_HALT = 3'b111;

   localparam logic [1:0] MOV_REG = 2'b00;
   localparam logic [1:0] MOV_IMM = 2'b10;

   localparam logic [1:0] ALU_ADD = 2'b00;
   localparam logic [1:0] ALU_CMP = 2'b01;
   localparam logic [1:0] ALU_AND = 2'b10;
   localparam logic [1:0] ALU_MVN = 2'b11;

   localparam logic [1:0] NSEL_RN = 2'b00;
   localparam logic [1:0] NSEL_RD = 2'b01;
   localparam logic [1:0] NSEL_RM = 2'b10;

   localparam logic [1:0] VSEL_C   = 2'b00;
   localparam logic [1:0] VSEL_IMM = 2'b10;

   typedef enum logic [2:0] {
      C_MOVI = 3'd0,
      C_MOVR = 3'd1,
      C_ALU2 = 3'd2,
      C_MVN  = 3'd3,
      C_CMP  = 3'd4,
      C_HALT = 3'd5,
      C_ILL  = 3'd6
   } iclass_t;

   typedef struct packed {
      logic       mem_rd;
      logic       reset_pc;
      logic       load_pc;
      logic       load_ir;
      logic [1:0] nsel;
      logic       write;
      logic [1:0] vsel;
      logic       load_a;
      logic       load_b;
      logic       load_c;
      logic       load_s;
      logic       asel;
      logic       bsel;
      logic       retire;
      logic       halted;
   } ctrl_t;

   // Moore output decode; the class only matters in S_ALU (MOV reg / CMP variants).
   function automatic ctrl_t f_state_ctrl(input state_t s, input iclass_t c);
      ctrl_t v;
      v = '0;
      case (s)
         S_RST: begin
            v.reset_pc = 1'b1;
            v.load_pc  = 1'b1;
         end
         S_IF1: v.mem_rd = 1'b1;
         S_IF2: begin
            v.mem_rd  = 1'b1;
            v.load_ir = 1'b1;
         end
         S_UPC: v.load_pc = 1'b1;
         S_GETA: begin
            v.nsel   = NSEL_RN;
            v.load_a = 1'b1;
         end
         S_GETB: begin
            v.nsel   = NSEL_RM;
            v.load_b = 1'b1;
         end
         S_ALU: begin
            if (c == C_CMP) begin
               v.load_s = 1'b1;
               v.retire = 1'b1;
            end else begin
               v.load_c = 1'b1;
               v.asel   = (c == C_MOVR);
            end
         end
         S_WR: begin
            v.nsel   = NSEL_RD;
            v.vsel   = VSEL_C;
            v.write  = 1'b1;
            v.retire = 1'b1;
         end
         S_WRIMM: begin
            v.nsel   = NSEL_RN;
            v.vsel   = VSEL_IMM;
            v.write  = 1'b1;
            v.retire = 1'b1;
         end
         S_HALT: v.halted = 1'b1;
         default: v = '0;
      endcase
      return v;
   endfunction

endpackage
`default_nettype wire

// File: rtl/smr_controller_if.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | smr_controller_if : controller <-> datapath strobe bundle             |
// | Revision          : 1.0                                              |
// +----------------------------------------------------------------------+
interface smr_controller_if;

   logic [15:0] ir;
   logic        mem_rd;
   logic        reset_pc;
   logic        load_pc;
   logic        load_ir;
   logic [1:0]  nsel;
   logic        write;
   logic [1:0]  vsel;
   logic        load_a;
   logic        load_b;
   logic        load_c;
   logic        load_s;
   logic        asel;
   logic        bsel;
   logic [1:0]  alu_op;
   logic        retire;
   logic        halted;
   logic        illegal;

   modport master (
      input  ir,
      output mem_rd, reset_pc, load_pc, load_ir, nsel, write, vsel,
             load_a, load_b, load_c, load_s, asel, bsel, alu_op,
             retire, halted, illegal
   );

   modport slave (
      output ir,
      input  mem_rd, reset_pc, load_pc, load_ir, nsel, write, vsel,
             load_a, load_b, load_c, load_s, asel, bsel, alu_op,
             retire, halted, illegal
   );

endinterface
`default_nettype wire

// File: rtl/smr_decode.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | smr_decode : instruction word -> instruction class and ALU opcode     |
// | Revision   : 1.0                                                     |
// +----------------------------------------------------------------------+
module smr_decode
   import smr_ctrl_pkg::*;
(
   input  wire logic [15:0] i_ir,
   output iclass_t          o_cls,
   output logic [1:0]       o_alu_op
);

   logic [2:0]  w_opcode;
   logic [1:0]  w_op;
   logic [10:0] w_unused_ir;

   assign w_opcode    = i_ir[15:13];
   assign w_op        = i_ir[12:11];
   assign w_unused_ir = i_ir[10:0];

   always_comb begin
      o_cls = C_ILL;
      case (w_opcode)
         OP_MOV: begin
            case (w_op)
               MOV_IMM: o_cls = C_MOVI;
               MOV_REG: o_cls = C_MOVR;
               default: o_cls = C_ILL;
            endcase
         end
         OP_ALU: begin
            case (w_op)
               ALU_CMP: o_cls = C_CMP;
               ALU_MVN: o_cls = C_MVN;
               default: o_cls = C_ALU2;
            endcase
         end
         OP_HALT: o_cls = C_HALT;
         default: o_cls = C_ILL;
      endcase
   end

   assign o_alu_op = (w_opcode == OP_ALU) ? w_op : ALU_ADD;

endmodule
`default_nettype wire

// File: rtl/smr_controller.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | smr_controller : Moore sequencer for the Simple RISC Machine datapath |
// | Revision       : 1.0                                                 |
// +----------------------------------------------------------------------+
module smr_controller
   import smr_ctrl_pkg::*;
#(
   parameter int PC_W = 8
) (
   input  wire logic        clk,
   input  wire logic        rst_n,
   smr_controller_if.master bus
);

   state_t     r_state;
   state_t     w_next;
   ctrl_t      r_ctrl;
   logic [1:0] r_alu_op;
   logic       r_illegal;
   iclass_t    w_cls;
   logic [1:0] w_alu_op;
   logic       w_unused_pc_w;

   assign w_unused_pc_w = PC_W[0];

   smr_decode u_decode (
      .i_ir     (bus.ir),
      .o_cls    (w_cls),
      .o_alu_op (w_alu_op)
   );

   always_comb begin
      w_next = r_state;
      case (r_state)
         S_RST:   w_next = S_IF1;
         S_IF1:   w_next = S_IF2;
         S_IF2:   w_next = S_UPC;
         S_UPC: begin
            case (w_cls)
               C_MOVI:        w_next = S_WRIMM;
               C_MOVR, C_MVN: w_next = S_GETB;
               C_ALU2, C_CMP: w_next = S_GETA;
               default:       w_next = S_HALT;
            endcase
         end
         S_GETA:  w_next = S_GETB;
         S_GETB:  w_next = S_ALU;
         S_ALU:   w_next = (w_cls == C_CMP) ? S_IF1 : S_WR;
         S_WR:    w_next = S_IF1;
         S_WRIMM: w_next = S_IF1;
         S_HALT:  w_next = S_HALT;
         default: w_next = S_RST;
      endcase
   end

   // Outputs are registered from the next state so every strobe is a clean
   // flop output and the async reset clears them together with the state.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state   <= S_RST;
         r_ctrl    <= f_state_ctrl(S_RST, C_HALT);
         r_alu_op  <= ALU_ADD;
         r_illegal <= 1'b0;
      end else begin
         r_state <= w_next;
         r_ctrl  <= f_state_ctrl(w_next, w_cls);
         if (r_state == S_UPC) begin
            r_alu_op <= w_alu_op;
         end else if (w_next == S_IF1) begin
            r_alu_op <= ALU_ADD;
         end
         if ((r_state == S_UPC) && (w_cls == C_ILL)) begin
            r_illegal <= 1'b1;
         end
      end
   end

   assign bus.mem_rd   = r_ctrl.mem_rd;
   assign bus.reset_pc = r_ctrl.reset_pc;
   assign bus.load_pc  = r_ctrl.load_pc;
   assign bus.load_ir  = r_ctrl.load_ir;
   assign bus.nsel     = r_ctrl.nsel;
   assign bus.write    = r_ctrl.write;
   assign bus.vsel     = r_ctrl.vsel;
   assign bus.load_a   = r_ctrl.load_a;
   assign bus.load_b   = r_ctrl.load_b;
   assign bus.load_c   = r_ctrl.load_c;
   assign bus.load_s   = r_ctrl.load_s;
   assign bus.asel     = r_ctrl.asel;
   assign bus.bsel     = r_ctrl.bsel;
   assign bus.alu_op   = r_alu_op;
   assign bus.retire   = r_ctrl.retire;
   assign bus.halted   = r_ctrl.halted;
   assign bus.illegal  = r_illegal;

endmodule
`default_nettype wire

// File: tb/tb_smr_controller.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_smr_controller : randomized self-checking bench for smr_controller |
// | Revision          : 1.0                                              |
// +----------------------------------------------------------------------+
`timescale 1ns/1ps
module tb_smr_controller;

   typedef struct packed {
      logic       mem_rd, reset_pc, load_pc, load_ir, write;
      logic       load_a, load_b, load_c, load_s, asel, bsel;
      logic       retire, halted, illegal;
      logic [1:0] nsel, vsel, alu_op;
   } obs_t;

   typedef struct {
      int         lat, n_wr, n_la, n_lb, n_lc, n_ls;
      logic [1:0] wr_nsel, wr_vsel, alu_op;
      logic       asel;
   } exp_t;

   logic clk;
   logic rst_n;
   int   tests;
   int   fails;
   int   onehot_viol;
   obs_t tr [32];
   int   tr_len;
   int   tr_ret;

   smr_controller_if bus ();

   smr_controller #(.PC_W(8)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   always @(negedge clk) begin
      if (rst_n === 1'b1 &&
          !$onehot0({bus.write, bus.load_a, bus.load_b, bus.load_c, bus.load_s}))
         onehot_viol++;
   end

   function automatic obs_t sample();
      obs_t o;
      o.mem_rd = bus.mem_rd;   o.reset_pc = bus.reset_pc; o.load_pc = bus.load_pc;
      o.load_ir = bus.load_ir; o.write = bus.write;       o.load_a = bus.load_a;
      o.load_b = bus.load_b;   o.load_c = bus.load_c;     o.load_s = bus.load_s;
      o.asel = bus.asel;       o.bsel = bus.bsel;         o.retire = bus.retire;
      o.halted = bus.halted;   o.illegal = bus.illegal;   o.nsel = bus.nsel;
      o.vsel = bus.vsel;       o.alu_op = bus.alu_op;
      return o;
   endfunction

   function automatic logic [10:0] strobes(input obs_t o);
      return {o.mem_rd, o.reset_pc, o.load_pc, o.load_ir, o.write, o.load_a,
              o.load_b, o.load_c, o.load_s, o.retire, o.bsel};
   endfunction

   // Reference: expected latency and per-strobe usage derived from the ISA rules.
   function automatic exp_t model(input logic [15:0] instr);
      exp_t       e;
      logic [2:0] opc;
      logic [1:0] op;
      opc = instr[15:13];
      op  = instr[12:11];
      e.lat = 0; e.n_wr = 0; e.n_la = 0; e.n_lb = 0; e.n_lc = 0; e.n_ls = 0;
      e.wr_nsel = 2'b01; e.wr_vsel = 2'b00; e.asel = 1'b0;
      e.alu_op = (opc == 3'b101) ? op : 2'b00;
      if (opc == 3'b110 && op == 2'b10) begin
         e.lat = 4; e.n_wr = 1; e.wr_nsel = 2'b00; e.wr_vsel = 2'b10;
      end else if (opc == 3'b110 && op == 2'b00) begin
         e.lat = 6; e.n_lb = 1; e.n_lc = 1; e.n_wr = 1; e.asel = 1'b1;
      end else if (opc == 3'b101 && op == 2'b11) begin
         e.lat = 6; e.n_lb = 1; e.n_lc = 1; e.n_wr = 1;
      end else if (opc == 3'b101 && op == 2'b01) begin
         e.lat = 6; e.n_la = 1; e.n_lb = 1; e.n_ls = 1;
      end else begin
         e.lat = 7; e.n_la = 1; e.n_lb = 1; e.n_lc = 1; e.n_wr = 1;
      end
      return e;
   endfunction

   // Drives one instruction from its IF1 cycle and records every cycle's outputs.
   task automatic run_instr(input logic [15:0] instr, input int max_cyc);
      tr_len = 0;
      tr_ret = -1;
      for (int k = 0; k < max_cyc; k++) begin
         @(negedge clk);
         tr[k]  = sample();
         tr_len = k + 1;
         if (tr[k].load_ir) bus.ir = instr;
         if (tr[k].retire) begin
            tr_ret = k;
            break;
         end
      end
   endtask

   task automatic do_reset();
      @(negedge clk);
      rst_n = 1'b0;
      @(negedge clk);
      @(negedge clk);
      rst_n = 1'b1;
   endtask

   task automatic test_reset();
      obs_t o;
      @(negedge clk);
      @(negedge clk);
      o = sample();
      tests++;
      if (o.reset_pc !== 1'b1 || o.load_pc !== 1'b1) begin
         fails++;
         $display("FAIL reset_pc_load_pc: got %b%b want 11", o.reset_pc, o.load_pc);
      end
      tests++;
      if ({o.mem_rd, o.load_ir, o.write, o.load_a, o.load_b, o.load_c, o.load_s,
           o.asel, o.bsel, o.retire, o.halted, o.illegal, o.nsel, o.vsel, o.alu_op} !== 18'd0) begin
         fails++;
         $display("FAIL reset_others: got %b want 0",
                  {o.mem_rd, o.load_ir, o.write, o.load_a, o.load_b, o.load_c, o.load_s,
                   o.asel, o.bsel, o.retire, o.halted, o.illegal, o.nsel, o.vsel, o.alu_op});
      end
      rst_n = 1'b1;
   endtask

   task automatic test_movi();
      for (int n = 0; n < 2; n++) begin
         run_instr(16'hD105, 10);
         tests++;
         if (tr[0].mem_rd !== 1'b1) begin
            fails++;
            $display("FAIL movi_if1_mem_rd[%0d]: got %b want 1", n, tr[0].mem_rd);
         end
         tests++;
         if (tr_ret !== 3) begin
            fails++;
            $display("FAIL movi_retire_cycle[%0d]: got %0d want 4", n, tr_ret + 1);
         end
         tests++;
         if ({tr[3].write, tr[3].nsel, tr[3].vsel} !== 5'b1_00_10) begin
            fails++;
            $display("FAIL movi_wrimm[%0d]: got w=%b nsel=%b vsel=%b want 1/00/10",
                     n, tr[3].write, tr[3].nsel, tr[3].vsel);
         end
      end
   endtask

   task automatic test_add();
      run_instr(16'hA162, 10);
      tests++;
      if (tr_ret !== 6) begin
         fails++;
         $display("FAIL add_retire_cycle: got %0d want 7", tr_ret + 1);
      end
      tests++;
      if ({tr[3].load_a, tr[3].nsel, tr[4].load_b, tr[4].nsel} !== 6'b1_00_1_10) begin
         fails++;
         $display("FAIL add_operands: got la=%b n=%b lb=%b n=%b want 1/00/1/10",
                  tr[3].load_a, tr[3].nsel, tr[4].load_b, tr[4].nsel);
      end
      tests++;
      if ({tr[5].load_c, tr[5].alu_op, tr[5].asel, tr[6].write, tr[6].nsel} !== 7'b1_00_0_1_01) begin
         fails++;
         $display("FAIL add_alu_wr: got lc=%b op=%b asel=%b w=%b n=%b want 1/00/0/1/01",
                  tr[5].load_c, tr[5].alu_op, tr[5].asel, tr[6].write, tr[6].nsel);
      end
   endtask

   task automatic test_mvn();
      int la;
      run_instr(16'hB8A2, 10);
      la = 0;
      for (int k = 0; k < tr_len; k++) la += int'(tr[k].load_a);
      tests++;
      if (tr_ret !== 5 || la !== 0) begin
         fails++;
         $display("FAIL mvn_seq: got retire=%0d load_a=%0d want 6/0", tr_ret + 1, la);
      end
      tests++;
      if ({tr[4].load_c, tr[4].alu_op} !== 3'b1_11) begin
         fails++;
         $display("FAIL mvn_alu_op: got lc=%b op=%b want 1/11", tr[4].load_c, tr[4].alu_op);
      end
   endtask

   task automatic test_cmp();
      int wr;
      run_instr(16'hA902, 10);
      wr = 0;
      for (int k = 0; k < tr_len; k++) wr += int'(tr[k].write);
      tests++;
      if (tr_ret !== 5 || wr !== 0) begin
         fails++;
         $display("FAIL cmp_seq: got retire=%0d writes=%0d want 6/0", tr_ret + 1, wr);
      end
      tests++;
      if ({tr[5].load_s, tr[5].load_c, tr[5].alu_op} !== 4'b1_0_01) begin
         fails++;
         $display("FAIL cmp_status: got ls=%b lc=%b op=%b want 1/0/01",
                  tr[5].load_s, tr[5].load_c, tr[5].alu_op);
      end
   endtask

   task automatic test_random();
      logic [15:0] r;
      exp_t        e;
      int          n_wr, n_la, n_lb, n_lc, n_ls, n_rd, n_ret, bad;
      for (int n = 0; n < 40; n++) begin
         r = 16'($urandom);
         case ($urandom_range(0, 5))
            0: r[15:11] = 5'b110_10;
            1: r[15:11] = 5'b110_00;
            2: r[15:11] = 5'b101_00;
            3: r[15:11] = 5'b101_10;
            4: r[15:11] = 5'b101_11;
            default: r[15:11] = 5'b101_01;
         endcase
         e = model(r);
         run_instr(r, 12);
         n_wr = 0; n_la = 0; n_lb = 0; n_lc = 0; n_ls = 0; n_rd = 0; n_ret = 0; bad = 0;
         for (int k = 0; k < tr_len; k++) begin
            n_wr += int'(tr[k].write);  n_la += int'(tr[k].load_a);
            n_lb += int'(tr[k].load_b); n_lc += int'(tr[k].load_c);
            n_ls += int'(tr[k].load_s); n_rd += int'(tr[k].mem_rd);
            n_ret += int'(tr[k].retire);
            if (tr[k].write && (tr[k].nsel !== e.wr_nsel || tr[k].vsel !== e.wr_vsel)) bad++;
            if (tr[k].load_a && tr[k].nsel !== 2'b00) bad++;
            if (tr[k].load_b && tr[k].nsel !== 2'b10) bad++;
            if ((tr[k].load_c || tr[k].load_s) && tr[k].alu_op !== e.alu_op) bad++;
            if (tr[k].load_c && tr[k].asel !== e.asel) bad++;
            if (tr[k].load_ir !== (k == 1)) bad++;
            if (tr[k].load_pc !== (k == 2)) bad++;
            if (tr[k].bsel !== 1'b0 || tr[k].halted !== 1'b0) bad++;
         end
         tests++;
         if (tr_ret !== e.lat - 1 || n_ret !== 1) begin
            fails++;
            $display("FAIL rnd_latency ir=%h: got %0d (retires=%0d) want %0d",
                     r, tr_ret + 1, n_ret, e.lat);
         end
         tests++;
         if (n_wr !== e.n_wr || n_la !== e.n_la || n_lb !== e.n_lb ||
             n_lc !== e.n_lc || n_ls !== e.n_ls) begin
            fails++;
            $display("FAIL rnd_strobes ir=%h: got w%0d a%0d b%0d c%0d s%0d want w%0d a%0d b%0d c%0d s%0d",
                     r, n_wr, n_la, n_lb, n_lc, n_ls, e.n_wr, e.n_la, e.n_lb, e.n_lc, e.n_ls);
         end
         tests++;
         if (n_rd !== 2 || tr[0].mem_rd !== 1'b1) begin
            fails++;
            $display("FAIL rnd_fetch ir=%h: got mem_rd count=%0d first=%b want 2/1",
                     r, n_rd, tr[0].mem_rd);
         end
         tests++;
         if (bad !== 0) begin
            fails++;
            $display("FAIL rnd_fields ir=%h: got %0d field errors want 0", r, bad);
         end
      end
   endtask

   task automatic test_stream();
      logic [15:0] prog [5];
      int          rets, gap;
      prog = '{16'hD105, 16'hD20A, 16'hA162, 16'hB0E3, 16'hE000};
      rets = 0;
      gap  = 0;
      for (int i = 0; i < 5; i++) begin
         run_instr(prog[i], (i == 4) ? 6 : 12);
         if (tr[0].mem_rd !== 1'b1) gap++;
         for (int k = 0; k < tr_len; k++) rets += int'(tr[k].retire);
      end
      tests++;
      if (rets !== 4) begin
         fails++;
         $display("FAIL stream_retires: got %0d want 4", rets);
      end
      tests++;
      if (gap !== 0) begin
         fails++;
         $display("FAIL stream_gap: got %0d late fetches want 0", gap);
      end
      tests++;
      if (tr[5].halted !== 1'b1) begin
         fails++;
         $display("FAIL stream_halted: got %b want 1", tr[5].halted);
      end
      tests++;
      if (onehot_viol !== 0) begin
         fails++;
         $display("FAIL onehot_strobes: got %0d violations want 0", onehot_viol);
      end
   endtask

   task automatic test_illegal();
      logic [15:0] bad_ir [2];
      bad_ir = '{16'h0000, 16'hC800};
      for (int i = 0; i < 2; i++) begin
         do_reset();
         run_instr(bad_ir[i], 8);
         tests++;
         if ({tr[2].halted, tr[2].illegal, tr[3].halted, tr[3].illegal,
              tr[7].halted, tr[7].illegal} !== 6'b00_11_11) begin
            fails++;
            $display("FAIL illegal ir=%h: got %b want 001111", bad_ir[i],
                     {tr[2].halted, tr[2].illegal, tr[3].halted, tr[3].illegal,
                      tr[7].halted, tr[7].illegal});
         end
      end
   endtask

   task automatic test_reset_mid();
      obs_t o;
      bit   hit;
      do_reset();
      hit = 0;
      for (int k = 0; k < 10; k++) begin
         @(negedge clk);
         o = sample();
         if (o.load_ir) bus.ir = 16'hA162;
         if (o.write) begin
            hit = 1;
            rst_n = 1'b0;
            #1;
            o = sample();
            break;
         end
      end
      tests++;
      if (!hit || {o.write, o.load_a, o.load_b, o.load_c, o.load_s, o.retire} !== 6'd0) begin
         fails++;
         $display("FAIL reset_mid_strobes: got hit=%0d strobes=%b want 1/000000", hit,
                  {o.write, o.load_a, o.load_b, o.load_c, o.load_s, o.retire});
      end
      tests++;
      if ({o.reset_pc, o.load_pc, o.mem_rd, o.illegal, o.halted} !== 5'b11_000) begin
         fails++;
         $display("FAIL reset_mid_state: got %b want 11000",
                  {o.reset_pc, o.load_pc, o.mem_rd, o.illegal, o.halted});
      end
      @(negedge clk);
      rst_n = 1'b1;
   endtask

   task automatic test_halt();
      int quiet;
      run_instr(16'hE000, 25);
      quiet = 0;
      for (int k = 3; k < 24; k++)
         if (strobes(tr[k]) !== 11'd0 || tr[k].halted !== 1'b1) quiet++;
      tests++;
      if ({tr[3].halted, tr[3].illegal} !== 2'b10 || tr_ret !== -1) begin
         fails++;
         $display("FAIL halt_flags: got halted=%b illegal=%b retire_at=%0d want 1/0/none",
                  tr[3].halted, tr[3].illegal, tr_ret + 1);
      end
      tests++;
      if (quiet !== 0 || tr[23].illegal !== 1'b0) begin
         fails++;
         $display("FAIL halt_quiet: got %0d busy cycles illegal=%b want 0/0", quiet, tr[23].illegal);
      end
   endtask

   initial begin
      tests       = 0;
      fails       = 0;
      onehot_viol = 0;
      rst_n       = 1'b0;
      bus.ir      = 16'h0000;
      test_reset();
      test_movi();
      test_add();
      test_mvn();
      test_cmp();
      test_random();
      test_stream();
      test_illegal();
      test_reset_mid();
      test_halt();
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
`default_nettype wire
